// File: rtl/alarm_multi_ctrl.sv
// Multi-slot alarm controller: matches BCD time against N slots, sequences
// RING/SNOOZE with snooze limit and auto-stop, and drives a gated tone output.
`timescale 1ns/1ps
module alarm_multi_ctrl #(
  parameter int unsigned N_ALARMS   = 4,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TONE_HZ    = 1000,
  parameter int unsigned BEEP_MS    = 250,
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned RING_MIN   = 5,
  localparam int unsigned AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
  localparam int unsigned SW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    minute_tick,
  input  logic [3:0]              hourdec_now,
  input  logic [3:0]              hourone_now,
  input  logic [3:0]              mindec_now,
  input  logic [3:0]              minone_now,
  input  logic [N_ALARMS-1:0]     alarm_en,
  input  logic [16*N_ALARMS-1:0]  alarm_time,
  input  logic                    btn_snooze,
  input  logic                    btn_off,
  output logic                    ringing,
  output logic                    snoozing,
  output logic [AW-1:0]           active_slot,
  output logic [SW-1:0]           snooze_cnt,
  output logic                    aud_pwm
);

  localparam int unsigned HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned BEEP = CLK_HZ / 1000 * BEEP_MS;
  localparam int unsigned TW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BW   = (BEEP > 1) ? $clog2(BEEP) : 1;
  localparam int unsigned RMW  = $clog2(RING_MIN + 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t         state, state_nxt;
  logic [15:0]    now_time;
  logic [15:0]    wake, wake_nxt, wake_calc;
  logic [AW-1:0]  slot_nxt, low_match, low_other;
  logic [SW-1:0]  scnt_nxt;
  logic [RMW-1:0] ring_min, rmin_nxt, rmin_inc;
  logic           any_match, other_match, en_active;
  logic           snooze_q, off_q, snooze_edge, off_edge;
  logic [7:0]     min_sum, hour_sum;
  logic           hour_carry;
  logic [TW-1:0]  tone_cnt, tone_cnt_nxt;
  logic [BW-1:0]  beep_cnt, beep_cnt_nxt;
  logic           tone, tone_nxt, beep_on, beep_nxt;

  assign now_time    = {hourdec_now, hourone_now, mindec_now, minone_now};
  assign snooze_edge = btn_snooze & ~snooze_q;
  assign off_edge    = btn_off & ~off_q;
  assign rmin_inc    = ring_min + RMW'(1);

  always_comb begin
    any_match   = 1'b0;
    other_match = 1'b0;
    low_match   = '0;
    low_other   = '0;
    en_active   = 1'b0;
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      if (alarm_en[i] && alarm_time[16*i +: 16] == now_time) begin
        if (!any_match) low_match = AW'(i);
        any_match = 1'b1;
        if (AW'(i) != active_slot && !other_match) begin
          low_other   = AW'(i);
          other_match = 1'b1;
        end
      end
      if (AW'(i) == active_slot) en_active = alarm_en[i];
    end
  end

  // Wake time: add in binary minutes/hours, then split back into BCD digits.
  always_comb begin
    hour_carry = 1'b0;
    min_sum    = 8'(mindec_now) * 8'd10 + 8'(minone_now) + 8'(SNOOZE_MIN);
    if (min_sum >= 8'd60) begin
      min_sum    = min_sum - 8'd60;
      hour_carry = 1'b1;
    end
    hour_sum = 8'(hourdec_now) * 8'd10 + 8'(hourone_now) + 8'(hour_carry);
    if (hour_sum >= 8'd24) hour_sum = hour_sum - 8'd24;
    wake_calc = {4'(hour_sum / 8'd10), 4'(hour_sum % 8'd10),
                 4'(min_sum / 8'd10), 4'(min_sum % 8'd10)};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = active_slot;
    scnt_nxt  = snooze_cnt;
    rmin_nxt  = ring_min;
    wake_nxt  = wake;
    case (state)
      IDLE: begin
        if (minute_tick && any_match) begin
          state_nxt = RING;
          slot_nxt  = low_match;
          scnt_nxt  = '0;
          rmin_nxt  = '0;
        end
      end
      RING: begin
        if (!en_active || off_edge) begin
          state_nxt = IDLE;
        end else if (snooze_edge && snooze_cnt < SW'(MAX_SNOOZE)) begin
          state_nxt = SNOOZE;
          scnt_nxt  = snooze_cnt + SW'(1);
          wake_nxt  = wake_calc;
        end else if (minute_tick) begin
          if (rmin_inc == RMW'(RING_MIN)) state_nxt = IDLE;
          else                            rmin_nxt  = rmin_inc;
        end
      end
      SNOOZE: begin
        if (!en_active || off_edge) begin
          state_nxt = IDLE;
        end else if (minute_tick && other_match) begin
          state_nxt = RING;
          slot_nxt  = low_other;
          scnt_nxt  = '0;
          rmin_nxt  = '0;
        end else if (minute_tick && now_time == wake) begin
          state_nxt = RING;
          rmin_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == IDLE) begin
      slot_nxt = '0;
      scnt_nxt = '0;
      rmin_nxt = '0;
    end
  end

  always_comb begin
    ringing  = (state == RING);
    snoozing = (state == SNOOZE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_slot <= '0;
      snooze_cnt  <= '0;
      ring_min    <= '0;
      wake        <= '0;
      snooze_q    <= 1'b0;
      off_q       <= 1'b0;
    end else begin
      active_slot <= slot_nxt;
      snooze_cnt  <= scnt_nxt;
      ring_min    <= rmin_nxt;
      wake        <= wake_nxt;
      snooze_q    <= btn_snooze;
      off_q       <= btn_off;
    end
  end

  // Tone/beep generators restart on every RING entry so the first RING cycle is audible.
  always_comb begin
    tone_cnt_nxt = '0;
    beep_cnt_nxt = '0;
    tone_nxt     = 1'b0;
    beep_nxt     = 1'b0;
    if (state_nxt == RING) begin
      if (state != RING) begin
        tone_nxt = 1'b1;
        beep_nxt = 1'b1;
      end else begin
        if (tone_cnt == TW'(HALF - 1)) begin
          tone_nxt = ~tone;
        end else begin
          tone_cnt_nxt = tone_cnt + TW'(1);
          tone_nxt     = tone;
        end
        if (beep_cnt == BW'(BEEP - 1)) begin
          beep_nxt = ~beep_on;
        end else begin
          beep_cnt_nxt = beep_cnt + BW'(1);
          beep_nxt     = beep_on;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tone_cnt <= '0;
      beep_cnt <= '0;
      tone     <= 1'b0;
      beep_on  <= 1'b0;
      aud_pwm  <= 1'b0;
    end else begin
      tone_cnt <= tone_cnt_nxt;
      beep_cnt <= beep_cnt_nxt;
      tone     <= tone_nxt;
      beep_on  <= beep_nxt;
      aud_pwm  <= (state_nxt == RING) && tone_nxt && beep_nxt;
    end
  end

endmodule

// File: tb/tb_alarm_multi_ctrl.sv
// Randomized bench for alarm_multi_ctrl against a minute-of-day reference model.
`timescale 1ns/1ps
module tb_alarm_multi_ctrl;

  localparam int NA = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          minute_tick;
  logic [3:0]    hourdec_now, hourone_now, mindec_now, minone_now;
  logic [NA-1:0] alarm_en;
  logic [16*NA-1:0] alarm_time;
  logic          btn_snooze, btn_off;
  logic          ringing, snoozing, aud_pwm;
  logic [1:0]    active_slot, snooze_cnt;

  alarm_multi_ctrl #(
    .N_ALARMS(NA), .CLK_HZ(1000), .TONE_HZ(100), .BEEP_MS(20),
    .SNOOZE_MIN(9), .MAX_SNOOZE(3), .RING_MIN(5)
  ) dut (
    .clk(clk), .rstn(rstn), .minute_tick(minute_tick),
    .hourdec_now(hourdec_now), .hourone_now(hourone_now),
    .mindec_now(mindec_now), .minone_now(minone_now),
    .alarm_en(alarm_en), .alarm_time(alarm_time),
    .btn_snooze(btn_snooze), .btn_off(btn_off),
    .ringing(ringing), .snoozing(snoozing), .active_slot(active_slot),
    .snooze_cnt(snooze_cnt), .aud_pwm(aud_pwm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus state: time of day and slot times kept as minutes since midnight
  int tod;
  int gap;
  int slot_min [NA];

  // Reference model: mode 0=idle 1=ring 2=snooze, k = cycles since ring entry
  int m_mode, m_slot, m_scnt, m_rmin, m_wake, m_k;
  bit m_psn, m_poff;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int t);
    int h, m;
    h = t / 60;
    m = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_slot = 0; m_scnt = 0; m_rmin = 0; m_wake = 0; m_k = 0;
    m_psn = 1'b0; m_poff = 1'b0;
  endtask

  task automatic drive();
    logic [15:0] now_bcd;
    int i;
    if (gap == 0) begin
      minute_tick = 1'b1;
      tod = (tod + 1) % 1440;
      gap = $urandom_range(20, 70);
    end else begin
      minute_tick = 1'b0;
      gap--;
    end
    now_bcd = to_bcd(tod);
    {hourdec_now, hourone_now, mindec_now, minone_now} = now_bcd;
    if ($urandom_range(0, 29) == 0) btn_snooze = ~btn_snooze;
    if ($urandom_range(0, 249) == 0) btn_off = ~btn_off;
    if ($urandom_range(0, 399) == 0 && !btn_off && !btn_snooze) begin
      btn_off = 1'b1;
      btn_snooze = 1'b1;
    end
    if ($urandom_range(0, 599) == 0) begin
      i = $urandom_range(0, NA - 1);
      alarm_en[i] = ~alarm_en[i];
    end
    if ($urandom_range(0, 149) == 0) begin
      i = $urandom_range(0, NA - 1);
      slot_min[i] = (tod + $urandom_range(0, 3)) % 1440;
      alarm_en[i] = 1'b1;
      if ($urandom_range(0, 2) == 0) slot_min[(i + 1) % NA] = slot_min[i];
    end
    for (int s = 0; s < NA; s++) alarm_time[16*s +: 16] = to_bcd(slot_min[s]);
  endtask

  task automatic model_step();
    bit sn_e, off_e, go_idle, enter;
    int low, lowo;
    sn_e  = btn_snooze && !m_psn;
    off_e = btn_off && !m_poff;
    m_psn  = btn_snooze;
    m_poff = btn_off;
    low = -1; lowo = -1;
    for (int s = 0; s < NA; s++) begin
      if (alarm_en[s] && slot_min[s] == tod) begin
        if (low < 0) low = s;
        if (s != m_slot && lowo < 0) lowo = s;
      end
    end
    go_idle = 1'b0;
    enter   = 1'b0;
    case (m_mode)
      0: if (minute_tick && low >= 0) begin
           m_mode = 1; m_slot = low; m_scnt = 0; m_rmin = 0; enter = 1'b1;
         end
      1: if (!alarm_en[m_slot] || off_e) go_idle = 1'b1;
         else if (sn_e && m_scnt < 3) begin
           m_mode = 2; m_scnt++; m_wake = (tod + 9) % 1440;
         end else if (minute_tick) begin
           m_rmin++;
           if (m_rmin == 5) go_idle = 1'b1;
         end
      default: if (!alarm_en[m_slot] || off_e) go_idle = 1'b1;
         else if (minute_tick && lowo >= 0) begin
           m_mode = 1; m_slot = lowo; m_scnt = 0; m_rmin = 0; enter = 1'b1;
         end else if (minute_tick && tod == m_wake) begin
           m_mode = 1; m_rmin = 0; enter = 1'b1;
         end
    endcase
    if (go_idle) begin
      m_mode = 0; m_slot = 0; m_scnt = 0; m_rmin = 0;
    end
    if (enter) m_k = 0;
    else if (m_mode == 1) m_k++;
  endtask

  task automatic compare_all();
    bit exp_aud;
    exp_aud = (m_mode == 1) && ((m_k / 5) % 2 == 0) && ((m_k / 20) % 2 == 0);
    check("ringing", 32'(ringing), 32'(m_mode == 1));
    check("snoozing", 32'(snoozing), 32'(m_mode == 2));
    check("active_slot", 32'(active_slot), 32'(m_slot));
    check("snooze_cnt", 32'(snooze_cnt), 32'(m_scnt));
    check("aud_pwm", 32'(aud_pwm), 32'(exp_aud));
  endtask

  task automatic run_cycle();
    drive();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ringing"}, 32'(ringing), 0);
    check({tag, "_snoozing"}, 32'(snoozing), 0);
    check({tag, "_active_slot"}, 32'(active_slot), 0);
    check({tag, "_snooze_cnt"}, 32'(snooze_cnt), 0);
    check({tag, "_aud_pwm"}, 32'(aud_pwm), 0);
  endtask

  int start_tod [4] = '{7*60 + 27, 23*60 + 52, 5*60 + 57, 0};

  initial begin
    rstn = 1'b0;
    minute_tick = 1'b0;
    btn_snooze = 1'b0;
    btn_off = 1'b1;
    alarm_en = '0;
    alarm_time = '0;
    {hourdec_now, hourone_now, mindec_now, minone_now} = '0;
    tod = 0;
    gap = 5;
    model_reset();
    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int ep = 0; ep < 4; ep++) begin
      tod = (ep == 3) ? int'($urandom_range(0, 1439)) : start_tod[ep];
      gap = $urandom_range(2, 10);
      for (int s = 0; s < NA; s++) begin
        slot_min[s] = (tod + 1 + s) % 1440;
        alarm_en[s] = 1'b1;
      end
      slot_min[3] = slot_min[0];
      for (int c = 0; c < 2000; c++) run_cycle();

      // Bounded wait for a ring, then reset asynchronously between edges
      for (int c = 0; c < 3000 && m_mode != 1; c++) begin
        if (c % 200 == 0) begin
          slot_min[$urandom_range(0, NA - 1)] = (tod + 1) % 1440;
          alarm_en = '1;
        end
        run_cycle();
      end
      check("ring_wait", 32'(ringing), 1);
      #2;
      rstn = 1'b0;
      btn_off = 1'b1;
      #1;
      check_zero("async_rst");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int c = 0; c < 2000; c++) run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_multi_ctrl.md
Name: alarm_multi_ctrl

Overview:
- Multi-slot alarm controller with snooze, auto-stop and gated-tone audio output.
- Sits between the BCD time-of-day counter and the board audio pin; replaces the single fixed alarm compare.
- Takes current HH:MM in BCD plus a minute tick.
- Compares against N programmable alarm slots, sequences RING/SNOOZE, and drives aud_pwm.

Parameters:
- N_ALARMS, 4, number of alarm slots (1..16)
- CLK_HZ, 100_000_000, clk frequency in Hz
- TONE_HZ, 1000, square-wave tone frequency
- BEEP_MS, 250, beep on-time and off-time in ms
- SNOOZE_MIN, 9, snooze delay in minutes (1..59)
- MAX_SNOOZE, 3, snoozes allowed per alarm event
- RING_MIN, 5, minute ticks of ringing before auto-stop (>=1)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- minute_tick  in  1  one-cycle pulse; *_now already hold the new minute in that cycle
- hourdec_now  in  4  current hour tens (BCD)
- hourone_now  in  4  current hour units (BCD)
- mindec_now  in  4  current minute tens (BCD)
- minone_now  in  4  current minute units (BCD)
- alarm_en  in  N_ALARMS  per-slot enable
- alarm_time  in  16*N_ALARMS  slot i at [16i+15:16i] = {hourdec,hourone,mindec,minone}
- btn_snooze  in  1  synchronised level; rising edge detected internally
- btn_off  in  1  synchronised level; rising edge detected internally
- ringing  out  1  high in RING
- snoozing  out  1  high in SNOOZE
- active_slot  out  max(1,clog2(N_ALARMS))  slot being serviced
- snooze_cnt  out  clog2(MAX_SNOOZE+1)  snoozes used this event
- aud_pwm  out  1  gated tone

Behaviour:
- Reset (async, rstn=0):
  - State IDLE; all outputs 0.
  - Button edge registers, tone and beep counters, wake time and ring-minute counter all 0.
  - A button held high through reset release produces no edge until it is released and pressed again.
- Match(i): alarm_en[i] && alarm_time slot i == {now fields}, evaluated only in a minute_tick cycle. Raw 4-bit compare, no BCD validity check.
- Button edge: input high && previous-cycle register low.
- IDLE:
  - On minute_tick with any match, go to RING next cycle.
  - active_slot = lowest matching index; snooze_cnt=0; ring_min=0.
  - Button edges are ignored.
- RING:
  - ringing=1. On entry: tone counter=0, tone=1, beep counter=0, beep_on=1, so aud_pwm=1 in the first RING cycle.
  - Priority, highest first:
    1. alarm_en[active_slot]=0 -> IDLE.
    2. off edge -> IDLE.
    3. Snooze edge with snooze_cnt<MAX_SNOOZE -> SNOOZE. snooze_cnt+1; wake = now + SNOOZE_MIN. A snooze edge with snooze_cnt==MAX_SNOOZE is ignored.
    4. minute_tick: ring_min+1; when it reaches RING_MIN -> IDLE.
  - Matches of other slots are ignored.
- SNOOZE:
  - snoozing=1, aud_pwm=0.
  - Priority, highest first:
    1. alarm_en[active_slot]=0 -> IDLE.
    2. off edge -> IDLE.
    3. minute_tick with a match on a slot other than active_slot -> RING with the lowest such slot; snooze_cnt=0, ring_min=0.
    4. minute_tick with now==wake -> RING, same slot, ring_min=0.
  - Snooze edges are ignored.
- IDLE entry clears snooze_cnt and active_slot to 0.
- Wake arithmetic:
  - Minutes: m = 10*mindec+minone+SNOOZE_MIN; if m>=60, subtract 60 and carry 1 to the hour.
  - Hours: h = 10*hourdec+hourone+carry; if h>=24, h -= 24.
  - Stored back as BCD. 23:59 + 1 -> 00:00.
- Tone:
  - HALF = CLK_HZ/(2*TONE_HZ). Tone toggles when its counter reaches HALF-1, then the counter restarts.
  - BEEP = CLK_HZ/1000*BEEP_MS cycles. beep_on toggles every BEEP cycles.
  - aud_pwm = ringing && tone && beep_on, registered.
- Latency: ringing, snoozing, active_slot and snooze_cnt update one cycle after the causing tick or edge.

Test Plan:
Benches use CLK_HZ=1000, TONE_HZ=100, BEEP_MS=20 (HALF=5, BEEP=20).
1. Slot 2=07:30 enabled; tick at 07:30 -> next cycle ringing=1, active_slot=2; aud_pwm 5 high / 5 low for 20 cycles, then low for 20 cycles, repeating.
2. Slots 0 and 3 = 06:00, both enabled; tick at 06:00 -> active_slot=0. Same with alarm_en[0]=0 -> active_slot=3. Tick at 06:00 with both disabled -> stays IDLE.
3. Ringing at 23:55; snooze edge -> snoozing=1, snooze_cnt=1, aud_pwm=0. Ticks at 23:56..00:03 -> no change. Tick at 00:04 -> ringing=1.
4. MAX_SNOOZE=3 reached: 4th snooze edge -> stays RING, snooze_cnt=3. After RING_MIN=5 ticks -> IDLE, snooze_cnt=0, aud_pwm=0.
5. In RING, btn_off and btn_snooze rise in the same cycle -> IDLE. In SNOOZE, off edge in the wake-match tick cycle -> IDLE. In SNOOZE, slot 1 matches -> RING, active_slot=1, snooze_cnt=0.
6. rstn=0 mid-RING -> all outputs 0 without a clock edge. btn_off held high through reset release -> no event. Release then press during a later RING -> IDLE.
